// File: rtl/uart_cmd_hub_if.sv
// UART-side bundle for uart_cmd_hub: per-channel receive strobes/bytes and
// transmit strobes/bytes/busy flags, packed with channel i at bits [8i+7:8i].
interface uart_cmd_hub_if #(
  parameter int UARTS = 2
);
  logic [UARTS-1:0]   rx_valid;
  logic [8*UARTS-1:0] rx_data;
  logic [UARTS-1:0]   tx_busy;
  logic [UARTS-1:0]   tx_send;
  logic [8*UARTS-1:0] tx_data;

  // UART side: delivers received bytes and busy, consumes transmit requests
  modport master (
    output rx_valid, rx_data, tx_busy,
    input  tx_send, tx_data
  );

  // Hub side: consumes received bytes and busy, issues transmit requests
  modport slave (
    input  rx_valid, rx_data, tx_busy,
    output tx_send, tx_data
  );
endinterface

// File: rtl/uart_cmd_hub.sv
// Multi-channel UART command hub: per-channel receive FIFOs, a round-robin
// byte arbiter, an LED command decoder with optional echo and '?' status
// readback as two uppercase ASCII hex characters, plus a heartbeat counter.
// The interface instance must be built with the same UARTS value as the hub.
module uart_cmd_hub #(
  parameter int UARTS      = 2,
  parameter int LEDS       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 24,
  parameter int ECHO       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_cmd_hub_if.slave     uart,
  output logic [LEDS-1:0]   led,
  output logic              heartbeat,
  output logic [UARTS-1:0]  overflow
);

  localparam int CH_W  = (UARTS > 1) ? $clog2(UARTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_ECHO     = 3'd2;
  localparam logic [2:0] S_REPLY_HI = 3'd3;
  localparam logic [2:0] S_REPLY_LO = 3'd4;
  localparam logic [2:0] S_SETTLE   = 3'd5;

  logic [CNT_WIDTH-1:0] cnt;

  logic [7:0]       fifo_mem [UARTS][FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr   [UARTS];
  logic [PTR_W:0]   rd_ptr   [UARTS];
  logic [UARTS-1:0] fifo_empty;
  logic [UARTS-1:0] fifo_full;
  logic [UARTS-1:0] push;
  logic [UARTS-1:0] pop;
  logic [UARTS-1:0] ovf_set;

  logic [2:0]        state;
  logic [2:0]        after_settle;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   cur_ch;
  logic [7:0]        cur_byte;
  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;
  logic [7:0]        pop_byte;
  logic              busy_cur;
  logic [LEDS-1:0]   led_next;
  logic [7:0]        led_ext;
  logic [UARTS-1:0]  tx_send_c;
  logic [8*UARTS-1:0] tx_data_r;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Free-running heartbeat counter; wraps naturally at its width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign heartbeat = cnt[CNT_WIDTH-1];

  // FIFO status flags from wrapped pointers (extra MSB distinguishes full/empty)
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    for (int i = 0; i < UARTS; i++) begin
      fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      fifo_full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                      (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
    end
  end

  // Round-robin search for the first non-empty FIFO starting at rr_ptr
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = 0; k < UARTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= UARTS) idx = idx - UARTS;
      if (!sel_found && !fifo_empty[idx]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(idx);
      end
    end
  end

  // Push/pop/overflow decisions; a pop frees room for a same-cycle push
  always_comb begin
    pop = '0;
    if (state == S_IDLE && sel_found) pop[sel_ch] = 1'b1;
    push    = '0;
    ovf_set = '0;
    for (int i = 0; i < UARTS; i++) begin
      push[i]    = uart.rx_valid[i] && (!fifo_full[i] || pop[i]);
      ovf_set[i] = uart.rx_valid[i] && fifo_full[i] && !pop[i];
    end
    pop_byte = fifo_mem[sel_ch][rd_ptr[sel_ch][PTR_W-1:0]];
  end

  // FIFO storage; no reset needed since pointers define what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < UARTS; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i][PTR_W-1:0]] <= uart.rx_data[8*i +: 8];
    end
  end

  // FIFO read/write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < UARTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < UARTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // LED command decode of the latched byte
  always_comb begin
    led_next = led;
    for (int i = 0; i < LEDS; i++) begin
      if (cur_byte == 8'h31 + 8'(i)) led_next[i] = ~led[i];
    end
    if (cur_byte == 8'h63) led_next = '0;
    if (cur_byte == 8'h73) led_next = '1;
    led_ext = '0;
    led_ext[LEDS-1:0] = led;
    busy_cur = uart.tx_busy[cur_ch];
  end

  // Main FSM: arbitrate, decode, then echo and/or status reply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      after_settle <= S_IDLE;
      rr_ptr       <= '0;
      cur_ch       <= '0;
      cur_byte     <= '0;
      led          <= '0;
      tx_data_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            cur_byte <= pop_byte;
            cur_ch   <= sel_ch;
            if (int'(sel_ch) == UARTS - 1) rr_ptr <= '0;
            else                           rr_ptr <= sel_ch + 1'b1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          led <= led_next;
          if (ECHO != 0) begin
            tx_data_r[8*int'(cur_ch) +: 8] <= cur_byte;
            state <= S_ECHO;
          end else if (cur_byte == 8'h3F) begin
            tx_data_r[8*int'(cur_ch) +: 8] <= hex_char(led_ext[7:4]);
            state <= S_REPLY_HI;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ECHO: begin
          if (!busy_cur) begin
            after_settle <= (cur_byte == 8'h3F) ? S_REPLY_HI : S_IDLE;
            state        <= S_SETTLE;
          end
        end
        S_REPLY_HI: begin
          if (!busy_cur) begin
            after_settle <= S_REPLY_LO;
            state        <= S_SETTLE;
          end
        end
        S_REPLY_LO: begin
          if (!busy_cur) begin
            after_settle <= S_IDLE;
            state        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (after_settle == S_REPLY_HI)
            tx_data_r[8*int'(cur_ch) +: 8] <= hex_char(led_ext[7:4]);
          else if (after_settle == S_REPLY_LO)
            tx_data_r[8*int'(cur_ch) +: 8] <= hex_char(led_ext[3:0]);
          state <= after_settle;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky overflow flags; a fresh drop wins over a same-cycle 'c' clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= '0;
    end else begin
      for (int i = 0; i < UARTS; i++) begin
        if (ovf_set[i])
          overflow[i] <= 1'b1;
        else if (state == S_DECODE && cur_byte == 8'h63 && int'(cur_ch) == i)
          overflow[i] <= 1'b0;
      end
    end
  end

  // Transmit strobe fires in the first cycle the serviced channel is not busy
  always_comb begin
    tx_send_c = '0;
    if ((state == S_ECHO || state == S_REPLY_HI || state == S_REPLY_LO) && !busy_cur)
      tx_send_c[cur_ch] = 1'b1;
  end

  assign uart.tx_send = tx_send_c;
  assign uart.tx_data = tx_data_r;

endmodule
